// File: rtl/dma_line_sched.sv
// Per-line DMA scheduler: paces ZP and DP DMA against the CPU tick within each line
// and drives the 6502 halt/int/ready controls.
module dma_line_sched #(
    parameter int COL_W         = 8,
    parameter int START_TICKS   = 7,
    parameter int STARTUP_TICKS = 2,
    parameter int ZP_TICK       = 96,
    parameter int KILL_TICK     = 106,
    parameter int FIRST_VIS     = 16,
    parameter int VIS_NTSC      = 243,
    parameter int VIS_PAL       = 293,
    parameter int DLI_LEN       = 2
) (
    input  logic             pclk_0,
    input  logic             reset,
    input  logic             enable,
    input  logic             pal_mode,
    input  logic             line_start,
    input  logic             frame_start,
    input  logic             zp_written,
    input  logic             zp_dma_done,
    input  logic             dp_dma_done,
    input  logic             dp_dli,
    input  logic             deassert_ready,
    output logic             halt_b,
    output logic             int_b,
    output logic             ready,
    output logic             zp_dma_start,
    output logic             dp_dma_start,
    output logic             dp_dma_kill,
    output logic             lram_swap,
    output logic             last_line,
    output logic [8:0]       line_num,
    output logic [COL_W-1:0] tick,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        VWAIT      = 3'd0,
        ZP_STARTUP = 3'd1,
        ZP_DMA     = 3'd2,
        HWAIT      = 3'd3,
        SOL        = 3'd4,
        DP_STARTUP = 3'd5,
        DP_DMA     = 3'd6,
        COOLDOWN   = 3'd7
    } state_e;

    localparam logic [8:0]       LAST_NTSC = 9'(FIRST_VIS + VIS_NTSC - 1);
    localparam logic [8:0]       LAST_PAL  = 9'(FIRST_VIS + VIS_PAL - 1);
    localparam logic [8:0]       ZP_LINE   = 9'(FIRST_VIS - 1);
    localparam logic [COL_W-1:0] ZP_AT     = COL_W'(ZP_TICK);
    localparam logic [COL_W-1:0] KILL_AT   = COL_W'(KILL_TICK);
    localparam logic [7:0]       SOL_CNT   = 8'(START_TICKS);
    localparam logic [7:0]       SU_CNT    = 8'(STARTUP_TICKS);
    localparam logic [7:0]       DLI_CNT   = 8'(DLI_LEN);

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       int_cnt_q, int_cnt_d;
    logic             halt_q, halt_d;
    logic             dli_q, dli_d;
    logic             killed_q, killed_d;
    logic             zp_start_q, zp_start_d;
    logic             dp_start_q, dp_start_d;
    logic             ready_q, ready_d;
    logic             swap_q;
    logic             pal_q, pal_d;
    logic [COL_W-1:0] tick_q, tick_d;
    logic [8:0]       line_q, line_d;
    logic             kill_w;
    logic             last_w;

    assign kill_w = (state_q == DP_DMA) && (tick_q == KILL_AT);
    assign last_w = (line_q == (pal_q ? LAST_PAL : LAST_NTSC));

    // Line/tick position, PAL latch and ready are independent of the FSM.
    always_comb begin
        tick_d = tick_q;
        if (line_start) begin
            tick_d = '0;
        end else if (tick_q != '1) begin
            tick_d = tick_q + COL_W'(1);
        end

        line_d = line_q;
        if (frame_start) begin
            line_d = '0;
        end else if (line_start && (line_q != 9'h1FF)) begin
            line_d = line_q + 9'd1;
        end

        pal_d = frame_start ? pal_mode : pal_q;

        ready_d = ready_q;
        if (deassert_ready) begin
            ready_d = 1'b0;
        end else if (line_start) begin
            ready_d = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        halt_d     = halt_q;
        dli_d      = dli_q;
        killed_d   = killed_q;
        zp_start_d = 1'b0;
        dp_start_d = 1'b0;
        int_cnt_d  = (int_cnt_q != 8'd0) ? int_cnt_q - 8'd1 : int_cnt_q;

        // A new frame abandons whatever DMA is in flight.
        if (frame_start) begin
            state_d  = VWAIT;
            halt_d   = 1'b1;
            dli_d    = 1'b0;
            killed_d = 1'b0;
        end else begin
            case (state_q)
                VWAIT: begin
                    if (enable && zp_written && (line_q == ZP_LINE) && (tick_q == ZP_AT)) begin
                        halt_d  = 1'b0;
                        cnt_d   = 8'd1;
                        state_d = ZP_STARTUP;
                    end
                end
                ZP_STARTUP: begin
                    if (cnt_q == SU_CNT) begin
                        zp_start_d = 1'b1;
                        state_d    = ZP_DMA;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ZP_DMA: begin
                    if (zp_dma_done) begin
                        dli_d    = dp_dli;
                        killed_d = 1'b0;
                        state_d  = COOLDOWN;
                    end
                end
                HWAIT: begin
                    if (line_start) begin
                        halt_d = 1'b1;
                        if (last_w) begin
                            state_d = VWAIT;
                        end else if (enable) begin
                            cnt_d   = 8'd1;
                            state_d = SOL;
                        end
                    end
                end
                SOL: begin
                    if (!enable) begin
                        halt_d  = 1'b1;
                        state_d = HWAIT;
                    end else if (cnt_q == SOL_CNT) begin
                        halt_d  = 1'b0;
                        cnt_d   = 8'd1;
                        state_d = DP_STARTUP;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                DP_STARTUP: begin
                    if (cnt_q == SU_CNT) begin
                        dp_start_d = 1'b1;
                        state_d    = DP_DMA;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                DP_DMA: begin
                    if (dp_dma_done || kill_w) begin
                        dli_d    = dp_dli;
                        killed_d = kill_w;
                        state_d  = COOLDOWN;
                    end
                end
                COOLDOWN: begin
                    // A killed line keeps the CPU halted until the next line_start.
                    if (!killed_q) begin
                        halt_d = 1'b1;
                    end
                    if (dli_q) begin
                        int_cnt_d = DLI_CNT;
                    end
                    state_d = HWAIT;
                end
                default: begin
                    state_d = VWAIT;
                end
            endcase
        end
    end

    always_ff @(posedge pclk_0 or posedge reset) begin
        if (reset) begin
            state_q    <= VWAIT;
            cnt_q      <= 8'd0;
            int_cnt_q  <= 8'd0;
            halt_q     <= 1'b1;
            dli_q      <= 1'b0;
            killed_q   <= 1'b0;
            zp_start_q <= 1'b0;
            dp_start_q <= 1'b0;
            ready_q    <= 1'b1;
            swap_q     <= 1'b0;
            pal_q      <= 1'b0;
            tick_q     <= '0;
            line_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            int_cnt_q  <= int_cnt_d;
            halt_q     <= halt_d;
            dli_q      <= dli_d;
            killed_q   <= killed_d;
            zp_start_q <= zp_start_d;
            dp_start_q <= dp_start_d;
            ready_q    <= ready_d;
            swap_q     <= line_start;
            pal_q      <= pal_d;
            tick_q     <= tick_d;
            line_q     <= line_d;
        end
    end

    assign halt_b       = halt_q;
    assign int_b        = (int_cnt_q == 8'd0);
    assign ready        = ready_q;
    assign zp_dma_start = zp_start_q;
    assign dp_dma_start = dp_start_q;
    assign dp_dma_kill  = kill_w;
    assign lram_swap    = swap_q;
    assign last_line    = last_w;
    assign line_num     = line_q;
    assign tick         = tick_q;
    assign state_dbg    = state_q;

endmodule
